// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data-memory responder.
//
// Contents:
//   DATA_W / ADDR_W   data and byte-address widths of the CPU load/store port
//   CNT_W             width of the wait-state down-counter
//   dmem_state_t      responder FSM states
//   access_legal()    doubleword-aligned and inside the array
package dmem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // The index is compared at full width so that large addresses never
    // alias back into the array through truncated index bits.
    function automatic logic access_legal(input logic [ADDR_W-1:0] addr,
                                          input int depth);
        return (addr[2:0] == 3'b000) &&
               ({3'b000, addr[ADDR_W-1:3]} < 64'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port doubleword storage for dmem_responder.
//
// Ports:
//   clk     rising-edge clock
//   we      write enable, stores wdata at addr
//   re      read enable, loads rdata from addr (rdata holds otherwise)
//   addr    doubleword index
//   wdata   write data
//   rdata   registered read data
//
// No reset: contents and the read register survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the LEGv8 load/store port.
//
// Accepts one request (memread / memwrite pulse) while idle, waits LATENCY
// cycles, then completes it with a one-cycle mem_ready pulse. Misaligned,
// out-of-range and read+write requests complete with mem_error and zero data
// after the same latency, without touching the array.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   memread            read request pulse
//   memwrite           write request pulse
//   main_aluresult     byte address
//   datamem_writedata  store data
//   datamem_readdata   load data, valid with mem_ready
//   mem_ready          one-cycle completion pulse
//   mem_busy           request in flight
//   mem_error          rejected access, qualifies mem_ready
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request pulse
// WAIT  | counting down wait states; counter==1 moves to RESP next
// RESP  | single completion cycle, mem_ready high
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] main_aluresult,
    input  logic [DATA_W-1:0] datamem_writedata,
    output logic [DATA_W-1:0] datamem_readdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_error
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
    localparam bit             ZERO_LAT = (LATENCY == 0);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [AW-1:0]     req_idx_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_write_q;
    logic              req_err_q;

    logic              rd_valid_q;

    logic              req;
    logic              in_err;
    logic [AW-1:0]     in_idx;

    logic              accept;
    logic              enter_resp;
    logic [AW-1:0]     acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_write;
    logic              acc_err;

    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    assign req    = memread | memwrite;
    assign in_err = ~access_legal(main_aluresult, DEPTH) | (memread & memwrite);
    assign in_idx = main_aluresult[AW+2:3];

    // With zero latency the array is accessed on the acceptance edge itself,
    // so the access fields come straight from the port while idle and from
    // the request latches otherwise.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        acc_idx    = req_idx_q;
        acc_wdata  = req_wdata_q;
        acc_write  = req_write_q;
        acc_err    = req_err_q;

        case (state_q)
            IDLE: begin
                acc_idx   = in_idx;
                acc_wdata = datamem_writedata;
                acc_write = memwrite;
                acc_err   = in_err;
                if (req) begin
                    accept = 1'b1;
                    cnt_d  = LAT_LOAD;
                    if (ZERO_LAT) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // <= rather than == so a corrupted zero count cannot stall
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign arr_we = enter_resp &  acc_write & ~acc_err;
    assign arr_re = enter_resp & ~acc_write & ~acc_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            req_err_q   <= 1'b0;
            mem_error   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_idx_q   <= in_idx;
                req_wdata_q <= datamem_writedata;
                req_write_q <= memwrite;
                req_err_q   <= in_err;
            end
            mem_error <= enter_resp & acc_err;
            if (arr_re) begin
                rd_valid_q <= 1'b1;
            end else if (enter_resp && acc_err) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // The array's read register has no reset; rd_valid_q zeroes the port
    // after reset and after an error response until the next good read.
    assign datamem_readdata = rd_valid_q ? arr_rdata : '0;
    assign mem_busy         = (state_q != IDLE);
    assign mem_ready        = (state_q == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH  = 128;
    localparam int PERIOD = 10;

    logic        clk;
    logic        rst_n     [2];
    logic        memread   [2];
    logic        memwrite  [2];
    logic [63:0] alu       [2];
    logic [63:0] wdata     [2];
    logic [63:0] rdata     [2];
    logic        ready     [2];
    logic        busy      [2];
    logic        merr      [2];

    logic [63:0] ref_mem [2][DEPTH];
    logic [63:0] exp_rd  [2];
    time         last_ready_t [2];

    int n_checks;
    int n_errors;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_lat2 (
        .clk               (clk),
        .reset             (rst_n[0]),
        .memread           (memread[0]),
        .memwrite          (memwrite[0]),
        .main_aluresult    (alu[0]),
        .datamem_writedata (wdata[0]),
        .datamem_readdata  (rdata[0]),
        .mem_ready         (ready[0]),
        .mem_busy          (busy[0]),
        .mem_error         (merr[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_lat0 (
        .clk               (clk),
        .reset             (rst_n[1]),
        .memread           (memread[1]),
        .memwrite          (memwrite[1]),
        .main_aluresult    (alu[1]),
        .datamem_writedata (wdata[1]),
        .datamem_readdata  (rdata[1]),
        .mem_ready         (ready[1]),
        .mem_busy          (busy[1]),
        .mem_error         (merr[1])
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // mode 0: plain transaction
    // mode 1: pulse a write of 0xAAAA to 0x10 in the first busy cycle
    // mode 2: assert reset in the first busy cycle (abort)
    task automatic do_op(input int s, input bit rd, input bit wr,
                         input logic [63:0] addr, input logic [63:0] wd, input int mode);
        int          n;
        int          lat;
        bit          err;
        logic [63:0] idx;
        bit          exp_err;
        lat = lat_of(s);
        check_val("idle_busy", 64'(busy[s]), 64'd0);
        check_val("idle_ready", 64'(ready[s]), 64'd0);
        memread[s]  = rd;
        memwrite[s] = wr;
        alu[s]      = addr;
        wdata[s]    = wd;
        @(negedge clk);
        memread[s]  = 1'b0;
        memwrite[s] = 1'b0;
        alu[s]      = {$urandom(), $urandom()};
        wdata[s]    = {$urandom(), $urandom()};
        check_val("busy_after_accept", 64'(busy[s]), 64'd1);

        if (mode == 2) begin
            rst_n[s] = 1'b0;
            #1;
            check_val("rst_busy", 64'(busy[s]), 64'd0);
            check_val("rst_ready", 64'(ready[s]), 64'd0);
            check_val("rst_error", 64'(merr[s]), 64'd0);
            check_val("rst_rdata", rdata[s], 64'd0);
            exp_rd[s] = 64'd0;
            @(negedge clk);
            rst_n[s] = 1'b1;
            @(negedge clk);
            return;
        end

        if (mode == 1) begin
            memwrite[s] = 1'b1;
            alu[s]      = 64'h10;
            wdata[s]    = 64'hAAAA;
        end

        n = 1;
        while (!ready[s] && n < 40) begin
            @(negedge clk);
            memwrite[s] = 1'b0;
            n++;
        end
        memwrite[s] = 1'b0;
        last_ready_t[s] = $time;

        idx = addr >> 3;
        err = (addr[2:0] != 3'd0) || (idx >= 64'(DEPTH)) || (rd && wr);
        if (err) begin
            exp_err   = 1'b1;
            exp_rd[s] = 64'd0;
        end else if (wr) begin
            exp_err = 1'b0;
            ref_mem[s][idx[6:0]] = wd;
        end else begin
            exp_err   = 1'b0;
            exp_rd[s] = ref_mem[s][idx[6:0]];
        end

        check_val("latency", 64'(n), 64'(lat + 1));
        check_val("resp_busy", 64'(busy[s]), 64'd1);
        check_val("resp_error", 64'(merr[s]), 64'(exp_err));
        check_val("resp_rdata", rdata[s], exp_rd[s]);
        @(negedge clk);
    endtask

    initial begin
        time t0, t1, t2;
        n_checks = 0;
        n_errors = 0;
        for (int s = 0; s < 2; s++) begin
            rst_n[s]    = 1'b0;
            memread[s]  = 1'b0;
            memwrite[s] = 1'b0;
            alu[s]      = 64'd0;
            wdata[s]    = 64'd0;
            exp_rd[s]   = 64'd0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_val("reset_rdata", rdata[s], 64'd0);
            check_val("reset_ready", 64'(ready[s]), 64'd0);
            check_val("reset_busy", 64'(busy[s]), 64'd0);
            check_val("reset_error", 64'(merr[s]), 64'd0);
            rst_n[s] = 1'b1;
        end
        @(negedge clk);

        // give every location a known value
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                do_op(s, 1'b0, 1'b1, 64'(i) << 3, {$urandom(), $urandom()}, 0);
            end
        end

        // store/load, latency 2
        do_op(0, 1'b0, 1'b1, 64'h10, 64'h1122334455667788, 0);
        do_op(0, 1'b1, 1'b0, 64'h10, 64'd0, 0);
        check_val("load_0x10", rdata[0], 64'h1122334455667788);

        // store/load, latency 0
        do_op(1, 1'b0, 1'b1, 64'h0, 64'hDEADBEEF, 0);
        do_op(1, 1'b1, 1'b0, 64'h0, 64'd0, 0);
        check_val("load_0x0_lat0", rdata[1], 64'h00000000DEADBEEF);

        // illegal accesses
        do_op(0, 1'b1, 1'b0, 64'h13, 64'd0, 0);
        do_op(0, 1'b1, 1'b0, 64'h400, 64'd0, 0);
        do_op(0, 1'b1, 1'b1, 64'h10, 64'hFFFF_0000_FFFF_0000, 0);
        do_op(1, 1'b0, 1'b1, 64'h400, 64'h1234, 0);
        do_op(0, 1'b1, 1'b0, 64'h10, 64'd0, 0);
        check_val("after_illegal_0x10", rdata[0], 64'h1122334455667788);

        // request pulse while busy is ignored
        do_op(0, 1'b1, 1'b0, 64'h10, 64'd0, 1);
        do_op(0, 1'b1, 1'b0, 64'h10, 64'd0, 0);
        check_val("busy_reject_0x10", rdata[0], 64'h1122334455667788);

        // reset while a write is waiting
        do_op(0, 1'b0, 1'b1, 64'h18, 64'h5555, 2);
        do_op(0, 1'b1, 1'b0, 64'h18, 64'd0, 0);

        // back-to-back reads at the earliest legal cycles
        for (int s = 0; s < 2; s++) begin
            do_op(s, 1'b1, 1'b0, 64'h0, 64'd0, 0);
            t0 = last_ready_t[s];
            do_op(s, 1'b1, 1'b0, 64'h8, 64'd0, 0);
            t1 = last_ready_t[s];
            do_op(s, 1'b1, 1'b0, 64'h10, 64'd0, 0);
            t2 = last_ready_t[s];
            check_val("b2b_spacing_1", 64'(t1 - t0), 64'((lat_of(s) + 2) * PERIOD));
            check_val("b2b_spacing_2", 64'(t2 - t1), 64'((lat_of(s) + 2) * PERIOD));
        end

        // randomized traffic
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 150; k++) begin
                int          kind;
                bit          rd;
                bit          wr;
                logic [63:0] a;
                kind = $urandom_range(0, 9);
                rd   = $urandom_range(0, 1) == 1;
                wr   = !rd;
                a    = 64'($urandom_range(0, DEPTH - 1)) << 3;
                if (kind == 7) begin
                    a = a | 64'($urandom_range(1, 7));
                end else if (kind == 8) begin
                    a = ({$urandom(), $urandom()} | 64'h400) & ~64'h7;
                end else if (kind == 9) begin
                    rd = 1'b1;
                    wr = 1'b1;
                end
                do_op(s, rd, wr, a, {$urandom(), $urandom()}, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
